// File: rtl/fuzzy_pkg.sv
// Shared widths, FSM encoding, rule consequents and output saturation for the
// weighted-average defuzzifier.
package fuzzy_pkg;

    localparam int W_MU   = 16;
    localparam int W_NUM  = 37;
    localparam int W_DEN  = 20;
    localparam int W_ABS  = 35;
    localparam int N_RULE = 9;

    localparam logic signed [W_MU-1:0] OUT_DEFAULT = 16'sd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DIV   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Singleton consequents, index = 3*T_term + dT_term.
    localparam logic signed [W_MU-1:0] RULE_C [0:N_RULE-1] = '{
        -16'sd24000, -16'sd16000, -16'sd8000,
        -16'sd8000,   16'sd0,      16'sd8000,
         16'sd8000,   16'sd16000,  16'sd24000
    };

    function automatic logic signed [W_MU-1:0] sat_apply(
        input logic            neg,
        input logic [W_MU-1:0] mag,
        input logic            ovf
    );
        logic signed [W_MU-1:0] r;
        if (neg) begin
            if (ovf || (mag > 16'd32768)) r = 16'sh8000;
            else                          r = $signed(16'd0 - mag);
        end else begin
            if (ovf || (mag > 16'd32767)) r = 16'sh7FFF;
            else                          r = $signed(mag);
        end
        return r;
    endfunction

endpackage

// File: rtl/defuzz_wavg_if.sv
// Weight-set input handshake and crisp-result output handshake of the defuzzifier.
interface defuzz_wavg_if;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        w00, w01, w02, w10, w11, w12, w20, w21, w22;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_value;
    logic               zero_w;

    modport master (
        output in_valid, w00, w01, w02, w10, w11, w12, w20, w21, w22, out_ready,
        input  in_ready, out_valid, out_value, zero_w
    );

    modport slave (
        input  in_valid, w00, w01, w02, w10, w11, w12, w20, w21, w22, out_ready,
        output in_ready, out_valid, out_value, zero_w
    );
endinterface

// File: rtl/defuzz_div.sv
// 35-bit by 20-bit serial restoring divider; the start cycle already performs
// the first quotient step so 35 bits finish in 35 edges.
module defuzz_div
    import fuzzy_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W_ABS-1:0] dividend,
    input  logic [W_DEN-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [W_MU-1:0]  quot,
    output logic             ovf
);

    logic [W_DEN-1:0] rem_r, dvs_r;
    logic [W_ABS-1:0] q_r;
    logic [5:0]       cnt_r;
    logic             busy_r, done_r;

    logic [W_DEN-1:0] src_rem_s, src_d_s, rem_nx_s;
    logic [W_ABS-1:0] src_q_s, q_nx_s;
    logic [W_DEN:0]   trial_s, diff_s;
    logic             fits_s;

    // One restoring step on either the fresh operands or the running state.
    always_comb begin
        src_rem_s = start ? {W_DEN{1'b0}} : rem_r;
        src_q_s   = start ? dividend      : q_r;
        src_d_s   = start ? divisor       : dvs_r;
        trial_s   = {src_rem_s, src_q_s[W_ABS-1]};
        diff_s    = trial_s - {1'b0, src_d_s};
        fits_s    = (trial_s >= {1'b0, src_d_s});
        if (fits_s) rem_nx_s = diff_s[W_DEN-1:0];
        else        rem_nx_s = trial_s[W_DEN-1:0];
        q_nx_s    = {src_q_s[W_ABS-2:0], fits_s};
    end

    // Iteration state; done pulses for one cycle after the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r  <= {W_DEN{1'b0}};
            dvs_r  <= {W_DEN{1'b0}};
            q_r    <= {W_ABS{1'b0}};
            cnt_r  <= 6'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            rem_r  <= rem_nx_s;
            q_r    <= q_nx_s;
            dvs_r  <= divisor;
            cnt_r  <= 6'd34;
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            rem_r  <= rem_nx_s;
            q_r    <= q_nx_s;
            cnt_r  <= cnt_r - 6'd1;
            busy_r <= (cnt_r != 6'd1);
            done_r <= (cnt_r == 6'd1);
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign quot = q_r[W_MU-1:0];
    assign ovf  = |q_r[W_ABS-1:W_MU];

endmodule

// File: rtl/defuzz_wavg.sv
// Singleton-centroid defuzzifier: nine serial MACs, then |num|/den through the
// serial divider, sign restore and saturation into a 16-bit crisp output.
module defuzz_wavg
    import fuzzy_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    defuzz_wavg_if.slave  bus
);

    state_t                  state_r, state_nx;
    logic [W_MU-1:0]         w_r [0:N_RULE-1];
    logic [3:0]              idx_r;
    logic signed [W_NUM-1:0] num_r;
    logic [W_DEN-1:0]        den_r;
    logic                    neg_r, zero_w_r;
    logic signed [W_MU-1:0]  out_value_r;

    logic [W_MU-1:0]         w_sel_s;
    logic signed [W_MU-1:0]  c_sel_s;
    logic signed [32:0]      w_ext_s, c_ext_s, prod_s;
    logic [W_ABS-1:0]        num_abs_s;
    logic                    div_start_s, div_busy_s, div_done_s, div_ovf_s;
    logic [W_MU-1:0]         div_quot_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nx;
    end

    // Next-state decode; idx 9 is the post-MAC decision cycle.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE:    if (bus.in_valid) state_nx = ACCUM; else state_nx = IDLE;
            ACCUM: begin
                if (idx_r == 4'd9) state_nx = (den_r == {W_DEN{1'b0}}) ? DONE : DIV;
                else               state_nx = ACCUM;
            end
            DIV:     if (div_done_s)    state_nx = DONE;  else state_nx = DIV;
            DONE:    if (bus.out_ready) state_nx = IDLE;  else state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs and divider launch, all decoded from registered state.
    always_comb begin
        bus.in_ready  = (state_r == IDLE);
        bus.out_valid = (state_r == DONE);
        div_start_s   = (state_r == ACCUM) && (idx_r == 4'd9) &&
                        (den_r != {W_DEN{1'b0}}) && !div_busy_s;
    end

    // MAC operand select and 16u x 16s product.
    always_comb begin
        w_sel_s = 16'd0;
        c_sel_s = 16'sd0;
        if (idx_r < 4'd9) begin
            w_sel_s = w_r[idx_r];
            c_sel_s = RULE_C[idx_r];
        end else begin
            w_sel_s = 16'd0;
            c_sel_s = 16'sd0;
        end
        w_ext_s   = {17'd0, w_sel_s};
        c_ext_s   = {{17{c_sel_s[15]}}, c_sel_s};
        prod_s    = w_ext_s * c_ext_s;
        num_abs_s = num_r[W_NUM-1] ? W_ABS'(-num_r) : num_r[W_ABS-1:0];
    end

    // Datapath: weight latch, accumulation, result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_RULE; i++) w_r[i] <= 16'd0;
            idx_r       <= 4'd0;
            num_r       <= '0;
            den_r       <= {W_DEN{1'b0}};
            neg_r       <= 1'b0;
            zero_w_r    <= 1'b0;
            out_value_r <= OUT_DEFAULT;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        w_r[0] <= bus.w00; w_r[1] <= bus.w01; w_r[2] <= bus.w02;
                        w_r[3] <= bus.w10; w_r[4] <= bus.w11; w_r[5] <= bus.w12;
                        w_r[6] <= bus.w20; w_r[7] <= bus.w21; w_r[8] <= bus.w22;
                        idx_r    <= 4'd0;
                        num_r    <= '0;
                        den_r    <= {W_DEN{1'b0}};
                        zero_w_r <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (idx_r < 4'd9) begin
                        num_r <= num_r + {{4{prod_s[32]}}, prod_s};
                        den_r <= den_r + {4'd0, w_sel_s};
                        idx_r <= idx_r + 4'd1;
                    end else if (den_r == {W_DEN{1'b0}}) begin
                        out_value_r <= OUT_DEFAULT;
                        zero_w_r    <= 1'b1;
                    end else begin
                        neg_r <= num_r[W_NUM-1];
                    end
                end
                DIV: begin
                    if (div_done_s) out_value_r <= sat_apply(neg_r, div_quot_s, div_ovf_s);
                end
                DONE:    out_value_r <= out_value_r;
                default: out_value_r <= out_value_r;
            endcase
        end
    end

    assign bus.out_value = out_value_r;
    assign bus.zero_w    = zero_w_r;

    defuzz_div u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start_s),
        .dividend (num_abs_s),
        .divisor  (den_r),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quot     (div_quot_s),
        .ovf      (div_ovf_s)
    );

endmodule

// File: tb/tb_defuzz_wavg.sv
// Randomized and directed bench for defuzz_wavg against a plain-arithmetic centroid model.
module tb_defuzz_wavg;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    defuzz_wavg_if bus();

    defuzz_wavg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int rc [9] = '{-24000, -16000, -8000, -8000, 0, 8000, 8000, 16000, 24000};

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_w(input logic [15:0] wv [9]);
        bus.w00 = wv[0]; bus.w01 = wv[1]; bus.w02 = wv[2];
        bus.w10 = wv[3]; bus.w11 = wv[4]; bus.w12 = wv[5];
        bus.w20 = wv[6]; bus.w21 = wv[7]; bus.w22 = wv[8];
    endtask

    // Centroid reference: sum(w*c)/sum(w), truncated toward zero, saturated.
    task automatic model(input logic [15:0] wv [9], output longint ev, output longint ez,
                         output longint elat);
        longint n = 0;
        longint d = 0;
        longint q;
        for (int i = 0; i < 9; i++) begin
            n += longint'(wv[i]) * longint'(rc[i]);
            d += longint'(wv[i]);
        end
        if (d == 0) begin
            ev = 0; ez = 1; elat = 10;
        end else begin
            q = n / d;
            if (q > 32767)  q = 32767;
            if (q < -32768) q = -32768;
            ev = q; ez = 0; elat = 45;
        end
    endtask

    task automatic accept(input logic [15:0] wv [9]);
        int waitc = 0;
        while (bus.in_ready !== 1'b1 && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        check_eq("in_ready_before_accept", longint'(bus.in_ready), 1);
        drive_w(wv);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_set(input string tag, input logic [15:0] wv [9], input int hold);
        longint ev, ez, elat;
        logic [15:0] junk [9];
        int cyc = 0;
        model(wv, ev, ez, elat);
        bus.out_ready = (hold == 0);
        accept(wv);
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "/latency"}, cyc, elat);
        check_eq({tag, "/value"}, longint'(bus.out_value), ev);
        check_eq({tag, "/zero_w"}, longint'(bus.zero_w), ez);
        check_eq({tag, "/in_ready_busy"}, longint'(bus.in_ready), 0);
        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                for (int k = 0; k < 9; k++) junk[k] = 16'hFFFF - 16'(k);
                drive_w(junk);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            check_eq({tag, "/hold_valid"}, longint'(bus.out_valid), 1);
            check_eq({tag, "/hold_value"}, longint'(bus.out_value), ev);
            check_eq({tag, "/hold_in_ready"}, longint'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, "/popped_valid"}, longint'(bus.out_valid), 0);
        check_eq({tag, "/popped_in_ready"}, longint'(bus.in_ready), 1);
    endtask

    initial begin
        logic [15:0] wv [9];
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wv = '{default: 16'h0};
        drive_w(wv);
        repeat (3) @(negedge clk);
        check_eq("rst/in_ready", longint'(bus.in_ready), 1);
        check_eq("rst/out_valid", longint'(bus.out_valid), 0);
        check_eq("rst/out_value", longint'(bus.out_value), 0);
        check_eq("rst/zero_w", longint'(bus.zero_w), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_set("all_zero", wv, 0);
        wv = '{default: 16'h0}; wv[8] = 16'hFFFF;
        run_set("w22_full", wv, 0);
        wv[7] = 16'hFFFF;
        run_set("w21_w22", wv, 0);
        wv = '{default: 16'h0}; wv[0] = 16'd1; wv[1] = 16'd2;
        run_set("trunc_neg", wv, 0);
        wv = '{default: 16'h0}; wv[4] = 16'hFFFF;
        run_set("backpressure", wv, 10);

        // Reset in the middle of a divide.
        wv = '{default: 16'h0}; wv[8] = 16'hFFFF;
        accept(wv);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst/out_valid", longint'(bus.out_valid), 0);
        check_eq("midrst/in_ready", longint'(bus.in_ready), 1);
        check_eq("midrst/zero_w", longint'(bus.zero_w), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wv = '{default: 16'h0}; wv[0] = 16'hFFFF;
        run_set("after_rst", wv, 0);

        for (int t = 0; t < 25; t++) begin
            int mode = $urandom_range(0, 7);
            for (int k = 0; k < 9; k++) begin
                if (mode == 0)                       wv[k] = 16'h0;
                else if (mode < 4 && $urandom_range(0, 1) == 0) wv[k] = 16'h0;
                else if (mode == 4)                  wv[k] = 16'($urandom_range(0, 3));
                else                                 wv[k] = 16'($urandom_range(0, 65535));
            end
            run_set($sformatf("rand%0d", t), wv, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
